// File: rtl/pipe_ctrl_2023211063_pkg.sv
// Shared encodings for the pipeline hazard/redirect controller: flush levels and FSM states.
package pipe_ctrl_2023211063_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned HOLD_W    = 3;
  localparam int unsigned STATE_W   = 2;

  // A stage register flushes when the hold level reaches its own level.
  typedef enum logic [HOLD_W-1:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_e;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN   = 2'd0,
    ST_MC    = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_2023211063_if.sv
// Pipeline <-> controller signal bundle; the controller sits on the slave side.
interface pipe_ctrl_2023211063_if;
  import pipe_ctrl_2023211063_pkg::*;

  logic [REG_AW-1:0] id_rs1_raddr_i;
  logic [REG_AW-1:0] id_rs2_raddr_i;
  logic              id_rs1_re_i;
  logic              id_rs2_re_i;
  logic              ex_is_load_i;
  logic              ex_reg_we_i;
  logic [REG_AW-1:0] ex_reg_waddr_i;
  logic              ex_mc_req_i;
  logic              ex_mc_done_i;
  logic              jump_i;
  logic [XLEN-1:0]   jump_addr_i;
  logic              int_assert_i;
  logic [XLEN-1:0]   int_addr_i;

  logic              stall_flag_o;
  logic              front_stall_o;
  logic [HOLD_W-1:0] hold_flag_o;
  logic              jump_flag_o;
  logic [XLEN-1:0]   jump_addr_o;
  logic [XLEN-1:0]   stall_cnt_o;
  logic [XLEN-1:0]   flush_cnt_o;

  modport master (
    output id_rs1_raddr_i, id_rs2_raddr_i, id_rs1_re_i, id_rs2_re_i,
           ex_is_load_i, ex_reg_we_i, ex_reg_waddr_i, ex_mc_req_i, ex_mc_done_i,
           jump_i, jump_addr_i, int_assert_i, int_addr_i,
    input  stall_flag_o, front_stall_o, hold_flag_o, jump_flag_o, jump_addr_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_raddr_i, id_rs2_raddr_i, id_rs1_re_i, id_rs2_re_i,
           ex_is_load_i, ex_reg_we_i, ex_reg_waddr_i, ex_mc_req_i, ex_mc_done_i,
           jump_i, jump_addr_i, int_assert_i, int_addr_i,
    output stall_flag_o, front_stall_o, hold_flag_o, jump_flag_o, jump_addr_o,
           stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/hazard_det_2023211063.sv
// Load-use comparator: ID consumer reads a register the EX load is about to write.
module hazard_det_2023211063
  import pipe_ctrl_2023211063_pkg::*;
(
  input  logic [REG_AW-1:0] rs1_raddr,
  input  logic [REG_AW-1:0] rs2_raddr,
  input  logic              rs1_re,
  input  logic              rs2_re,
  input  logic              ex_is_load,
  input  logic              ex_reg_we,
  input  logic [REG_AW-1:0] ex_reg_waddr,
  output logic              load_use_c
);

  logic producer;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real producer, so writes to it cannot create a hazard.
  assign producer = ex_is_load & ex_reg_we & (ex_reg_waddr != REG_AW'(0));
  assign rs1_hit  = rs1_re & (rs1_raddr == ex_reg_waddr);
  assign rs2_hit  = rs2_re & (rs2_raddr == ex_reg_waddr);

  assign load_use_c = producer & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl_2023211063.sv
// Pipeline stall/flush/redirect controller with multi-cycle wait and deferred interrupt redirect.
module pipe_ctrl_2023211063
  import pipe_ctrl_2023211063_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  pipe_ctrl_2023211063_if.slave   bus
);

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [XLEN-1:0]   pend_addr_q, pend_addr_d;
  logic [XLEN-1:0]   stall_cnt_q;
  logic [XLEN-1:0]   flush_cnt_q;

  logic              load_use_c;
  logic              stall_c;
  logic              front_c;
  logic              jump_c;
  hold_e             hold_c;
  logic [XLEN-1:0]   jaddr_c;

  hazard_det_2023211063 u_hazard (
    .rs1_raddr    (bus.id_rs1_raddr_i),
    .rs2_raddr    (bus.id_rs2_raddr_i),
    .rs1_re       (bus.id_rs1_re_i),
    .rs2_re       (bus.id_rs2_re_i),
    .ex_is_load   (bus.ex_is_load_i),
    .ex_reg_we    (bus.ex_reg_we_i),
    .ex_reg_waddr (bus.ex_reg_waddr_i),
    .load_use_c   (load_use_c)
  );

  // Next state and zero-latency control decode.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    stall_c     = 1'b0;
    front_c     = 1'b0;
    jump_c      = 1'b0;
    hold_c      = HOLD_NONE;
    jaddr_c     = '0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.int_assert_i) begin
          jump_c  = 1'b1;
          jaddr_c = bus.int_addr_i;
          hold_c  = HOLD_ID;
        end else if (bus.jump_i) begin
          jump_c  = 1'b1;
          jaddr_c = bus.jump_addr_i;
          hold_c  = HOLD_ID;
        end else if (bus.ex_mc_req_i) begin
          if (!bus.ex_mc_done_i) begin
            stall_c = 1'b1;
            state_d = ST_MC;
          end
        end else if (load_use_c) begin
          front_c = 1'b1;
          hold_c  = HOLD_ID;
        end
      end
      ST_MC: begin
        // Only the first interrupt seen during the wait is kept.
        if (bus.int_assert_i && !pend_q) begin
          pend_d      = 1'b1;
          pend_addr_d = bus.int_addr_i;
        end
        if (!bus.ex_mc_done_i) begin
          stall_c = 1'b1;
        end else begin
          state_d = (pend_q || bus.int_assert_i) ? ST_REDIR : ST_RUN;
        end
      end
      ST_REDIR: begin
        jump_c  = 1'b1;
        jaddr_c = pend_addr_q;
        hold_c  = HOLD_ID;
        pend_d  = 1'b0;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Controls are forced inactive for as long as reset is held.
  assign bus.stall_flag_o  = rst & stall_c;
  assign bus.front_stall_o = rst & front_c;
  assign bus.jump_flag_o   = rst & jump_c;
  assign bus.hold_flag_o   = rst ? hold_c : HOLD_NONE;
  assign bus.jump_addr_o   = rst ? jaddr_c : '0;
  assign bus.stall_cnt_o   = stall_cnt_q;
  assign bus.flush_cnt_o   = flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      if (stall_c || front_c) stall_cnt_q <= stall_cnt_q + XLEN'(1);
      if (jump_c)             flush_cnt_q <= flush_cnt_q + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_2023211063.sv
// Directed bench for the pipeline controller: hazards, multi-cycle waits, redirects, counters, reset.
module tb_pipe_ctrl_2023211063;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [31:0] exp_stall;
  logic [31:0] exp_flush;

  pipe_ctrl_2023211063_if bus ();

  pipe_ctrl_2023211063 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.id_rs1_raddr_i = '0;
    bus.id_rs2_raddr_i = '0;
    bus.id_rs1_re_i    = 1'b0;
    bus.id_rs2_re_i    = 1'b0;
    bus.ex_is_load_i   = 1'b0;
    bus.ex_reg_we_i    = 1'b0;
    bus.ex_reg_waddr_i = '0;
    bus.ex_mc_req_i    = 1'b0;
    bus.ex_mc_done_i   = 1'b0;
    bus.jump_i         = 1'b0;
    bus.jump_addr_i    = '0;
    bus.int_assert_i   = 1'b0;
    bus.int_addr_i     = '0;
  endtask

  // Inputs change right after the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    bus.jump_i = 1'b1;  bus.jump_addr_i = 32'h1234;
    bus.ex_mc_req_i = 1'b1;
    bus.ex_is_load_i = 1'b1; bus.ex_reg_we_i = 1'b1; bus.ex_reg_waddr_i = 5'd5;
    bus.id_rs1_re_i = 1'b1;  bus.id_rs1_raddr_i = 5'd5;
    next_cycle(); next_cycle(); #1;
    n_cmp++; if (bus.stall_flag_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", bus.stall_flag_o); end
    n_cmp++; if (bus.front_stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_front got %b want 0", bus.front_stall_o); end
    n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL reset_hold got %0d want 0", bus.hold_flag_o); end
    n_cmp++; if (bus.jump_flag_o !== 1'b0) begin n_bad++; $display("FAIL reset_jump got %b want 0", bus.jump_flag_o); end
    n_cmp++; if (bus.jump_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_jaddr got %h want 0", bus.jump_addr_o); end
    n_cmp++; if (bus.stall_cnt_o !== 32'h0 || bus.flush_cnt_o !== 32'h0) begin n_bad++; $display("FAIL reset_cnt got %h/%h want 0/0", bus.stall_cnt_o, bus.flush_cnt_o); end
    next_cycle();
    idle();
    rst = 1'b1;
    exp_stall = 32'd0;
    exp_flush = 32'd0;
  endtask

  task automatic test_load_use();
    next_cycle();
    idle();
    bus.ex_is_load_i = 1'b1; bus.ex_reg_we_i = 1'b1; bus.ex_reg_waddr_i = 5'd5;
    bus.id_rs2_re_i = 1'b1;  bus.id_rs2_raddr_i = 5'd5;
    bus.id_rs1_raddr_i = 5'd7;
    #1;
    n_cmp++; if (bus.front_stall_o !== 1'b1) begin n_bad++; $display("FAIL lu_front got %b want 1", bus.front_stall_o); end
    n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_bad++; $display("FAIL lu_hold got %0d want 3", bus.hold_flag_o); end
    n_cmp++; if (bus.stall_flag_o !== 1'b0) begin n_bad++; $display("FAIL lu_stall got %b want 0", bus.stall_flag_o); end
    exp_stall = 32'd1;
    next_cycle();
    idle();
    #1;
    n_cmp++; if (bus.front_stall_o !== 1'b0) begin n_bad++; $display("FAIL lu_release got %b want 0", bus.front_stall_o); end
    n_cmp++; if (bus.stall_cnt_o !== exp_stall) begin n_bad++; $display("FAIL lu_cnt got %0d want %0d", bus.stall_cnt_o, exp_stall); end
    // destination x0: never a hazard
    next_cycle();
    bus.ex_is_load_i = 1'b1; bus.ex_reg_we_i = 1'b1; bus.ex_reg_waddr_i = 5'd0;
    bus.id_rs2_re_i = 1'b1;  bus.id_rs2_raddr_i = 5'd0;
    #1;
    n_cmp++; if (bus.front_stall_o !== 1'b0 || bus.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL lu_x0 got %b/%0d want 0/0", bus.front_stall_o, bus.hold_flag_o); end
    // matching address but the register is not read
    next_cycle();
    bus.ex_reg_waddr_i = 5'd9; bus.id_rs1_raddr_i = 5'd9; bus.id_rs1_re_i = 1'b0;
    bus.id_rs2_re_i = 1'b0;
    #1;
    n_cmp++; if (bus.front_stall_o !== 1'b0) begin n_bad++; $display("FAIL lu_no_re got %b want 0", bus.front_stall_o); end
    // rs1 path
    next_cycle();
    bus.id_rs1_re_i = 1'b1;
    #1;
    n_cmp++; if (bus.front_stall_o !== 1'b1) begin n_bad++; $display("FAIL lu_rs1 got %b want 1", bus.front_stall_o); end
    exp_stall = 32'd2;
    next_cycle();
    idle();
    #1;
    n_cmp++; if (bus.stall_cnt_o !== exp_stall) begin n_bad++; $display("FAIL lu_cnt2 got %0d want %0d", bus.stall_cnt_o, exp_stall); end
  endtask

  task automatic test_multicycle();
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      idle();
      bus.ex_mc_req_i  = 1'b1;
      bus.ex_mc_done_i = (c == 4);
      #1;
      n_cmp++;
      if (bus.stall_flag_o !== (c < 4)) begin
        n_bad++; $display("FAIL mc_stall_c%0d got %b want %b", c, bus.stall_flag_o, (c < 4));
      end
    end
    exp_stall = 32'd6;
    next_cycle();
    idle();
    #1;
    n_cmp++; if (bus.stall_cnt_o !== exp_stall) begin n_bad++; $display("FAIL mc_cnt got %0d want %0d", bus.stall_cnt_o, exp_stall); end
    n_cmp++; if (bus.stall_flag_o !== 1'b0 || bus.jump_flag_o !== 1'b0) begin n_bad++; $display("FAIL mc_after got %b/%b want 0/0", bus.stall_flag_o, bus.jump_flag_o); end
    // request that completes in the same cycle: no stall
    next_cycle();
    bus.ex_mc_req_i = 1'b1; bus.ex_mc_done_i = 1'b1;
    #1;
    n_cmp++; if (bus.stall_flag_o !== 1'b0) begin n_bad++; $display("FAIL mc_same_cycle got %b want 0", bus.stall_flag_o); end
  endtask

  task automatic test_mc_interrupt();
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      idle();
      bus.ex_mc_req_i  = 1'b1;
      bus.ex_mc_done_i = (c == 4);
      if (c == 2) begin bus.int_assert_i = 1'b1; bus.int_addr_i = 32'h80; end
      if (c == 3) begin bus.int_assert_i = 1'b1; bus.int_addr_i = 32'h99; bus.jump_i = 1'b1; bus.jump_addr_i = 32'h44; end
      #1;
      if (c == 2 || c == 3) begin
        n_cmp++;
        if (bus.jump_flag_o !== 1'b0 || bus.stall_flag_o !== 1'b1) begin
          n_bad++; $display("FAIL mci_wait_c%0d got jump %b stall %b want 0/1", c, bus.jump_flag_o, bus.stall_flag_o);
        end
      end
    end
    next_cycle();
    idle();
    #1;
    n_cmp++; if (bus.jump_flag_o !== 1'b1) begin n_bad++; $display("FAIL mci_jump got %b want 1", bus.jump_flag_o); end
    n_cmp++; if (bus.jump_addr_o !== 32'h80) begin n_bad++; $display("FAIL mci_addr got %h want 00000080", bus.jump_addr_o); end
    n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_bad++; $display("FAIL mci_hold got %0d want 3", bus.hold_flag_o); end
    exp_stall = 32'd10;
    exp_flush = 32'd1;
    next_cycle();
    #1;
    n_cmp++; if (bus.jump_flag_o !== 1'b0 || bus.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL mci_once got %b/%0d want 0/0", bus.jump_flag_o, bus.hold_flag_o); end
    n_cmp++; if (bus.stall_cnt_o !== exp_stall || bus.flush_cnt_o !== exp_flush) begin n_bad++; $display("FAIL mci_cnt got %0d/%0d want %0d/%0d", bus.stall_cnt_o, bus.flush_cnt_o, exp_stall, exp_flush); end
  endtask

  task automatic test_jump_priority();
    next_cycle();
    idle();
    bus.jump_i = 1'b1; bus.jump_addr_i = 32'h100;
    bus.int_assert_i = 1'b1; bus.int_addr_i = 32'h200;
    #1;
    n_cmp++; if (bus.jump_flag_o !== 1'b1 || bus.jump_addr_o !== 32'h200) begin n_bad++; $display("FAIL jp_int got %b/%h want 1/00000200", bus.jump_flag_o, bus.jump_addr_o); end
    n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_bad++; $display("FAIL jp_hold got %0d want 3", bus.hold_flag_o); end
    exp_flush = 32'd2;
    next_cycle();
    idle();
    bus.jump_i = 1'b1; bus.jump_addr_i = 32'h100;
    bus.ex_mc_req_i = 1'b1;
    #1;
    n_cmp++; if (bus.flush_cnt_o !== exp_flush) begin n_bad++; $display("FAIL jp_cnt got %0d want %0d", bus.flush_cnt_o, exp_flush); end
    n_cmp++; if (bus.jump_addr_o !== 32'h100 || bus.stall_flag_o !== 1'b0) begin n_bad++; $display("FAIL jp_plain got %h/%b want 00000100/0", bus.jump_addr_o, bus.stall_flag_o); end
    exp_flush = 32'd3;
    next_cycle();
    idle();
    #1;
    n_cmp++; if (bus.flush_cnt_o !== exp_flush || bus.stall_flag_o !== 1'b0) begin n_bad++; $display("FAIL jp_cnt2 got %0d/%b want %0d/0", bus.flush_cnt_o, bus.stall_flag_o, exp_flush); end
  endtask

  task automatic test_flush_wrap();
    next_cycle();
    idle();
    force dut.flush_cnt_q = 32'hFFFF_FFFF;
    next_cycle();
    release dut.flush_cnt_q;
    #1;
    n_cmp++; if (bus.flush_cnt_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_preload got %h want ffffffff", bus.flush_cnt_o); end
    next_cycle();
    bus.jump_i = 1'b1; bus.jump_addr_i = 32'h300;
    next_cycle();
    idle();
    #1;
    n_cmp++; if (bus.flush_cnt_o !== 32'h0) begin n_bad++; $display("FAIL wrap_zero got %h want 00000000", bus.flush_cnt_o); end
  endtask

  task automatic test_reset_mid_mc();
    next_cycle();
    idle();
    bus.ex_mc_req_i = 1'b1;
    next_cycle();
    bus.int_assert_i = 1'b1; bus.int_addr_i = 32'h80;
    next_cycle();
    bus.int_assert_i = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.stall_flag_o !== 1'b0 || bus.jump_flag_o !== 1'b0 || bus.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL rmid_outputs got %b/%b/%0d want 0/0/0", bus.stall_flag_o, bus.jump_flag_o, bus.hold_flag_o); end
    next_cycle();
    idle();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (bus.jump_flag_o !== 1'b0 || bus.stall_flag_o !== 1'b0) begin
        n_bad++; $display("FAIL rmid_after_c%0d got jump %b stall %b want 0/0", c, bus.jump_flag_o, bus.stall_flag_o);
      end
      next_cycle();
    end
    #1;
    n_cmp++; if (bus.stall_cnt_o !== 32'h0 || bus.flush_cnt_o !== 32'h0) begin n_bad++; $display("FAIL rmid_cnt got %0d/%0d want 0/0", bus.stall_cnt_o, bus.flush_cnt_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_load_use();
    test_multicycle();
    test_mc_interrupt();
    test_jump_priority();
    test_flush_wrap();
    test_reset_mid_mc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
